// File: rtl/wr_control.sv
// wr_control: staggered per-bank write sequencer for the systolic output memory.
// Bank i writes num_rows rows starting i cycles after bank 0.
module wr_control #(
    parameter int WIDTH_HEIGHT = 4,
    parameter int ADDR_W       = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic [ADDR_W-1:0]              num_rows,
    output logic [WIDTH_HEIGHT-1:0]        wr_en,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] wr_addr,
    output logic                           busy,
    output logic                           done
);

    // Step counter must reach (2^ADDR_W-1)+WIDTH_HEIGHT-2 without overflow.
    localparam int TW = ADDR_W + $clog2(WIDTH_HEIGHT) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state;
    logic [TW-1:0]     step;
    logic [TW-1:0]     last_step;
    logic [ADDR_W-1:0] rows;
    logic [ADDR_W-1:0] addr_q [WIDTH_HEIGHT];

    // Lane i is active for steps i .. i+r-1.
    function automatic logic [WIDTH_HEIGHT-1:0] lane_en(
        input logic [TW-1:0]     s,
        input logic [ADDR_W-1:0] r
    );
        lane_en = '0;
        for (int i = 0; i < WIDTH_HEIGHT; i++) begin
            lane_en[i] = (s >= TW'(i)) && (s < TW'(i) + TW'(r));
        end
    endfunction

    // Final step index of the job: rows + WIDTH_HEIGHT - 2.
    assign last_step = TW'(rows) + TW'(WIDTH_HEIGHT) - TW'(2);

    genvar g;
    generate
        for (g = 0; g < WIDTH_HEIGHT; g++) begin : g_pack
            assign wr_addr[ADDR_W*g +: ADDR_W] = addr_q[g];
        end
    endgenerate

    // Sequencer state, step counter, registered enables and lane addresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            step  <= '0;
            rows  <= '0;
            wr_en <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < WIDTH_HEIGHT; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH_HEIGHT; i++) begin
                if (wr_en[i]) begin
                    addr_q[i] <= addr_q[i] + ADDR_W'(1);
                end
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rows <= num_rows;
                        step <= '0;
                        for (int i = 0; i < WIDTH_HEIGHT; i++) begin
                            addr_q[i] <= base_addr;
                        end
                        if (num_rows != '0) begin
                            state <= S_WRITE;
                            busy  <= 1'b1;
                            wr_en <= lane_en('0, num_rows);
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (step == last_step) begin
                        state <= S_DONE;
                        wr_en <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        step  <= step + TW'(1);
                        wr_en <= lane_en(step + TW'(1), rows);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    wr_en <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wr_control.sv
// tb_wr_control: scoreboard bench for wr_control (WIDTH_HEIGHT=4, ADDR_W=8).
// Expected beats are queued at stimulus time and popped by a negedge monitor.
module tb_wr_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  num_rows;
    logic [3:0]  wr_en;
    logic [31:0] wr_addr;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] addr;
        logic        dn;
        logic        bz;
        logic        chk_addr;
        string       tag;
    } exp_t;

    exp_t sb[$];

    logic [3:0]  t2_en   [7] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    logic [31:0] t2_addr [7] = '{32'h10101010, 32'h10101011, 32'h10101112,
                                 32'h10111213, 32'h11121314, 32'h12131414,
                                 32'h13141414};

    wr_control #(.WIDTH_HEIGHT(4), .ADDR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Hand-written table for base 0x10, 4 rows.
    task automatic push_lit();
        exp_t e;
        for (int t = 0; t < 7; t++) begin
            e.en = t2_en[t];
            e.addr = t2_addr[t];
            e.dn = 1'b0;
            e.bz = 1'b1;
            e.chk_addr = 1'b1;
            e.tag = $sformatf("lit_t%0d", t);
            sb.push_back(e);
        end
        e.en = 4'h0;
        e.addr = 32'h14141414;
        e.dn = 1'b1;
        e.bz = 1'b0;
        e.chk_addr = 1'b1;
        e.tag = "lit_done";
        sb.push_back(e);
    endtask

    // Expected beats from the lane window definition; limit truncates a job.
    task automatic push_job(string tag, logic [7:0] base, logic [7:0] n, int limit);
        exp_t e;
        int   last;
        logic [7:0] a;
        last = int'(n) + 2;
        if (n != 0) begin
            for (int t = 0; t <= last && t < limit; t++) begin
                e.en = '0;
                e.addr = '0;
                for (int i = 0; i < 4; i++) begin
                    if (t < i) begin
                        a = base;
                    end else if (t < i + int'(n)) begin
                        a = base + 8'(t - i);
                        e.en[i] = 1'b1;
                    end else begin
                        a = base + n;
                    end
                    e.addr[8*i +: 8] = a;
                end
                e.dn = 1'b0;
                e.bz = 1'b1;
                e.chk_addr = 1'b1;
                e.tag = $sformatf("%s_t%0d", tag, t);
                sb.push_back(e);
            end
        end
        if (n == 0 || limit > last) begin
            a = base + n;
            e.en = 4'h0;
            e.addr = {a, a, a, a};
            e.dn = 1'b1;
            e.bz = 1'b0;
            e.chk_addr = (n != 0);
            e.tag = {tag, "_done"};
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start(logic [7:0] base, logic [7:0] n);
        base_addr = base;
        num_rows = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_job(string tag, logic [7:0] base, logic [7:0] n);
        push_job(tag, base, n, 1000);
        pulse_start(base, n);
        repeat (int'(n) + 6) tick();
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    // Monitor: every beat with a write or done must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en != 4'h0 || done) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected: en=%h addr=%h done=%b busy=%b",
                         wr_en, wr_addr, done, busy);
            end else begin
                e = sb.pop_front();
                if (wr_en !== e.en || done !== e.dn || busy !== e.bz ||
                    (e.chk_addr && wr_addr !== e.addr)) begin
                    bad++;
                    $display("FAIL %s: got en=%h addr=%h done=%b busy=%b want en=%h addr=%h done=%b busy=%b",
                             e.tag, wr_en, wr_addr, done, busy,
                             e.en, e.addr, e.dn, e.bz);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        base_addr = 8'h55;
        num_rows = 8'h03;

        // Reset held with start toggling.
        for (int c = 0; c < 3; c++) begin
            start = ~start;
            tick();
            check($sformatf("rst%0d_en", c), 32'(wr_en), 0);
            check($sformatf("rst%0d_addr", c), wr_addr, 0);
            check($sformatf("rst%0d_busy", c), 32'(busy), 0);
            check($sformatf("rst%0d_done", c), 32'(done), 0);
        end
        start = 1'b0;
        reset = 1'b0;
        tick();

        // Basic 4-row job, hand table.
        push_lit();
        pulse_start(8'h10, 8'd4);
        check("busy_t0", 32'(busy), 1);
        repeat (10) tick();
        check("basic_drained", sb.size(), 0);

        // Single row: diagonal enables, every lane at base.
        run_job("one", 8'h40, 8'd1);

        // Address wrap at top of range.
        run_job("wrap", 8'hFE, 8'd4);

        // Start during WRITE must be ignored.
        push_lit();
        pulse_start(8'h10, 8'd4);
        tick();
        tick();
        base_addr = 8'h77;
        num_rows = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("ignore_drained", sb.size(), 0);

        // Reset in the middle of a job.
        push_job("mid", 8'h20, 8'd5, 3);
        pulse_start(8'h20, 8'd5);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_en", 32'(wr_en), 0);
        check("midrst_addr", wr_addr, 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        reset = 1'b0;
        check("midrst_drained", sb.size(), 0);
        tick();
        run_job("clean", 8'h30, 8'd3);

        // Zero rows: immediate done pulse, no writes.
        push_job("zero", 8'h99, 8'd0, 1000);
        pulse_start(8'h99, 8'd0);
        check("zero_busy", 32'(busy), 0);
        check("zero_done", 32'(done), 1);
        tick();
        check("zero_done_clr", 32'(done), 0);
        repeat (3) tick();
        check("zero_drained", sb.size(), 0);

        // Larger job to exercise longer windows.
        run_job("long", 8'hF0, 8'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
